// File: rtl/hpc3_and_vec_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : hpc3_and_vec_pipe_pkg
// Brief  : Share-pair indexing and bit-slice helpers shared by HPC gadgets.
// Rev    : 1.0
// ============================================================================
package hpc3_and_vec_pipe_pkg;

  localparam int D_DEFAULT = 2;
  localparam int W_DEFAULT = 8;

  function automatic int num_pairs(input int d);
    return d * (d - 1) / 2;
  endfunction

  function automatic int rnd_width(input int d, input int w);
    return 2 * num_pairs(d) * w;
  endfunction

  // Lexicographic index of the unordered pair {i,j}, i != j.
  function automatic int pidx(input int i, input int j, input int d);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  function automatic int share_bit(input int i, input int k, input int w);
    return i * w + k;
  endfunction

  function automatic int rnd_bit(input int p, input int k, input int w);
    return p * w + k;
  endfunction

  function automatic int rndp_bit(input int p, input int k, input int d, input int w);
    return (num_pairs(d) + p) * w + k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpc3_and_vec_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : hpc3_and_vec_pipe_if
// Brief  : Operand, randomness and result handshakes of the vector HPC3 AND.
// Rev    : 1.0
// ============================================================================
interface hpc3_and_vec_pipe_if
  import hpc3_and_vec_pipe_pkg::*;
#(
  parameter int D = D_DEFAULT,
  parameter int W = W_DEFAULT
);
  localparam int RW = rnd_width(D, W);

  logic           in_valid;
  logic           in_ready;
  logic [D*W-1:0] a_sh;
  logic [D*W-1:0] b_sh;
  logic           rnd_valid;
  logic           rnd_ready;
  logic [RW-1:0]  rnd;
  logic           out_valid;
  logic           out_ready;
  logic [D*W-1:0] c_sh;

  modport master (
    output in_valid, a_sh, b_sh, rnd_valid, rnd, out_ready,
    input  in_ready, rnd_ready, out_valid, c_sh
  );

  modport slave (
    input  in_valid, a_sh, b_sh, rnd_valid, rnd, out_ready,
    output in_ready, rnd_ready, out_valid, c_sh
  );
endinterface
`default_nettype wire

// File: rtl/hpc3_and_vec_pipe_lane.sv
`default_nettype none
// ============================================================================
// Module : hpc3_lane_core
// Brief  : One lane of a D-share HPC3 AND gadget: stage-1 regs and XOR tree.
// Rev    : 1.0
// ============================================================================
module hpc3_lane_core
  import hpc3_and_vec_pipe_pkg::*;
#(
  parameter  int D = D_DEFAULT,
  localparam int P = num_pairs(D)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [D-1:0] a_i,
  input  logic [D-1:0] b_i,
  input  logic [P-1:0] r_i,
  input  logic [P-1:0] rp_i,
  output logic [D-1:0] c_o
);
  logic [D-1:0]   diag_q;
  logic [D-1:0]   diag_d;
  logic [D*D-1:0] uv;

  assign diag_d = a_i & b_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diag_q <= '0;
    end else if (en_i) begin
      diag_q <= diag_d;
    end
  end

  for (genvar i = 0; i < D; i++) begin : g_row
    for (genvar j = 0; j < D; j++) begin : g_col
      if (i == j) begin : g_self
        assign uv[i*D+j] = 1'b0;
      end else begin : g_pair
        localparam int PI = pidx(i, j, D);
        logic u_q, u_d, v_q, v_d;

        assign u_d = (a_i[i] & (b_i[j] ^ r_i[PI])) ^ rp_i[PI];
        assign v_d = (~a_i[i] & r_i[PI]) ^ rp_i[PI];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            u_q <= 1'b0;
            v_q <= 1'b0;
          end else if (en_i) begin
            u_q <= u_d;
            v_q <= v_d;
          end
        end

        assign uv[i*D+j] = u_q ^ v_q;
      end
    end

    // Output share built purely from register outputs.
    assign c_o[i] = diag_q[i] ^ (^uv[i*D +: D]);
  end
endmodule
`default_nettype wire

// File: rtl/hpc3_and_vec_pipe.sv
`default_nettype none
// ============================================================================
// Module : hpc3_and_vec_pipe
// Brief  : W-lane D-share HPC3 masked AND with valid/ready and randomness handshake.
// Rev    : 1.0
// ============================================================================
module hpc3_and_vec_pipe
  import hpc3_and_vec_pipe_pkg::*;
#(
  parameter int D    = D_DEFAULT,
  parameter int W    = W_DEFAULT,
  parameter int PIPE = 0
) (
  input  logic                clk,
  input  logic                rst,
  hpc3_and_vec_pipe_if.slave  bus
);
  localparam int P = num_pairs(D);

  logic           accept;
  logic           en1;
  logic           v1_q;
  logic           v1_d;
  logic [D*W-1:0] c1;

  // Reset gating keeps randomness from being consumed while in reset.
  assign accept        = bus.in_valid & bus.rnd_valid & en1 & ~rst;
  assign bus.in_ready  = en1 & bus.rnd_valid & ~rst;
  assign bus.rnd_ready = accept;
  assign v1_d          = accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else if (en1) begin
      v1_q <= v1_d;
    end
  end

  for (genvar k = 0; k < W; k++) begin : g_lane
    logic [D-1:0] a_l;
    logic [D-1:0] b_l;
    logic [D-1:0] c_l;
    logic [P-1:0] r_l;
    logic [P-1:0] rp_l;

    for (genvar i = 0; i < D; i++) begin : g_sh
      assign a_l[i]                  = bus.a_sh[share_bit(i, k, W)];
      assign b_l[i]                  = bus.b_sh[share_bit(i, k, W)];
      assign c1[share_bit(i, k, W)]  = c_l[i];
    end

    for (genvar p = 0; p < P; p++) begin : g_rnd
      assign r_l[p]  = bus.rnd[rnd_bit(p, k, W)];
      assign rp_l[p] = bus.rnd[rndp_bit(p, k, D, W)];
    end

    hpc3_lane_core #(.D(D)) u_core (
      .clk  (clk),
      .rst  (rst),
      .en_i (accept),
      .a_i  (a_l),
      .b_i  (b_l),
      .r_i  (r_l),
      .rp_i (rp_l),
      .c_o  (c_l)
    );
  end

  if (PIPE != 0) begin : g_pipe
    logic           v2_q;
    logic           en2;
    logic [D*W-1:0] c_q;

    assign en2 = ~v2_q | bus.out_ready;
    assign en1 = ~v1_q | en2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_q <= 1'b0;
        c_q  <= '0;
      end else if (en2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          c_q <= c1;
        end
      end
    end

    assign bus.out_valid = v2_q;
    assign bus.c_sh      = c_q;
  end else begin : g_comb
    assign en1           = ~v1_q | bus.out_ready;
    assign bus.out_valid = v1_q;
    assign bus.c_sh      = c1;
  end
endmodule
`default_nettype wire
